// File: rtl/instr_fetch.sv
// Instruction fetch: holds the PC, fetches one word per instruction and resolves the next PC on retire.
// Optional fetch-ack timeout is enabled with `define IFETCH_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one cycle after reset, no request
// S_FETCH | imem_req high at pc, waiting for imem_ack
// S_ISSUE | instr valid to decoder, waiting for instr_ready
// S_FAULT | misaligned target or fetch timeout, held until reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_control,
  input  logic [31:0] rs_data,
  input  logic        instr_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, instr_nxt, next_pc;
  logic        fault_nxt;
  logic        to_hit;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_ISSUE);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      3'b001:  next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      3'b010:  next_pc = rs_data;
      3'b011:  next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt;

  // Counter holds the number of ack-less FETCH cycles already elapsed.
  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != S_FETCH)
      to_cnt <= '0;
    else if (!imem_ack)
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    fault_nxt = fault;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        // An ack on the limit cycle still captures normally.
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          state_nxt = S_ISSUE;
        end else if (to_hit) begin
          fault_nxt = 1'b1;
          state_nxt = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_nxt = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
            state_nxt = S_FAULT;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      instr <= 32'd0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      fault <= fault_nxt;
    end
  end

endmodule
